// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional SERIAL_SUBTRACTOR_BORROW_IN_EN adds a chaining borrow input on the top.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_fsub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow to the next bit.
module fsub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock; result lands in diff after WIDTH cycles.
// Define SERIAL_SUBTRACTOR_BORROW_IN_EN to add borrow_in for chaining to a lower word.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// SHIFT | one full-subtract step per cycle, busy=1
// DONE  | result valid, done=1 for this cycle; start here launches the next op
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
   input  logic             borrow_in,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_diff;
   logic               r_borrow;
   logic               w_start_acc;
   logic               w_last;
   logic               w_bin_init;
   logic               w_d;
   logic               w_bout;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
   assign w_bin_init = borrow_in;
`else
   assign w_bin_init = 1'b0;
`endif

   assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

   fsub_cell u_fsub (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = SHIFT;
         SHIFT:   if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = start ? SHIFT : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // diff is not cleared at start: it fills from the MSB side as bits are produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else if (w_start_acc) begin
         r_cnt    <= '0;
         r_a      <= a;
         r_b      <= b;
         r_borrow <= w_bin_init;
      end else if (r_state == SHIFT) begin
         r_cnt    <= r_cnt + CNT_W'(1);
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_diff   <= {w_d, r_diff[WIDTH-1:1]};
         r_borrow <= w_bout;
      end
   end

   assign busy       = (r_state == SHIFT);
   assign done       = (r_state == DONE);
   assign diff       = r_diff;
   assign borrow_out = r_borrow;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand bit count (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: the minuend, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: the subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse indicating that the result is valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit: the final borrow, which is 1 when a < b as unsigned values.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL capture a and b into shift registers, clear the bit counter, clear the borrow flip-flop, and move the FSM to SHIFT.
REQ-013 The block SHALL ignore start while in SHIFT; the operands in flight SHALL be unaffected.
REQ-014 Each SHIFT cycle SHALL perform one full-subtract step:
- inputs: the LSBs of the a and b registers and the borrow flip-flop;
- the difference bit SHALL be shifted into the MSB of diff;
- the new borrow SHALL be registered;
- the a and b registers SHALL shift right by one.
REQ-015 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
- With start accepted at edge k, done SHALL be high for the single cycle following edge k+WIDTH.
REQ-016 Full-subtract equations: D = a^b^bin; Bout = (~a&b) | (~(a^b)&bin).
REQ-017 With no start, DONE SHALL return to IDLE on the next edge.
REQ-018 diff and borrow_out SHALL hold their values from DONE until the next accepted start.
- diff SHALL then show shifting intermediate values while busy=1; it is valid only when done=1 or in IDLE.
REQ-019 busy SHALL be 1 exactly in SHIFT.
REQ-020 Back-to-back operation: a start asserted in DONE SHALL be accepted, giving a throughput of one result per WIDTH+1 cycles.

Reset
REQ-021 When rst_n=0, the block SHALL immediately, independent of clk, force:
- FSM to IDLE;
- busy=0, done=0, diff=0, borrow_out=0;
- counter, shift registers and borrow flip-flop to 0.
REQ-022 A reset asserted during SHIFT SHALL abort the operation with no done pulse.
- After rst_n is released, the first rising edge SHALL be able to accept start.

Configuration
REQ-023 Macro SERIAL_SUBTRACTOR_BORROW_IN_EN, when defined, SHALL add input port borrow_in (1 bit), captured at start as the initial borrow so the block chains to a less-significant word.
- Without the macro, the port SHALL be absent and the initial borrow SHALL be 0.

Structure
REQ-024 Package serial_subtractor_pkg SHALL hold:
- the FSM state typedef (IDLE/SHIFT/DONE);
- the default WIDTH constant;
- the counter width, computed as $clog2(WIDTH+1).
REQ-025 The one-bit combinational step SHALL be a separate sub-module fsub_cell with ports a, b, bin, d and bout; there SHALL be no other sub-modules.

Verification
REQ-026 The bench SHALL cover the following directed scenarios, with WIDTH=8 unless stated:
- a=0x05, b=0x03, start pulse -> done exactly 9 cycles after the start edge (8 SHIFT edges plus the DONE cycle); diff=0x02, borrow_out=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0x00 -> diff=0x00, borrow_out=0; a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
- start re-asserted with new operands mid-SHIFT -> ignored; result for the original operands; a single done pulse.
- start held high through DONE with a=0x80, b=0x01 -> second operation accepted back-to-back, diff=0x7F, borrow_out=0.
- rst_n pulsed low at SHIFT cycle 4 -> outputs 0 immediately, no done; a new start then completes correctly.
- With SERIAL_SUBTRACTOR_BORROW_IN_EN: a=0x05, b=0x03, borrow_in=1 -> diff=0x01, borrow_out=0; a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1.
